int_priority_ctrl: RTL and testbench

Memory-mapped priority interrupt controller that sits between peripheral interrupt lines (timers, UART, external pins) and one HWInt input of the CP0 exception unit.
- Per source: latches edge- or level-type requests and applies an enable mask.
- Exposes a claim/complete interface so the handler identifies and retires the highest-priority source.
- Supports nesting: only strictly higher-priority sources re-raise irq while a lower-priority source is in service.
- Accessed by the M-stage bus bridge like other devices; the bridge decodes the base address.

---
 rtl/int_priority_ctrl_if.sv | 19 +
 rtl/int_priority_ctrl.sv | 113 +++++++++++
 tb/tb_int_priority_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/int_priority_ctrl_if.sv
// Bus port of the priority interrupt controller.
// The bridge drives the strobes; the controller returns rdata.
interface int_priority_ctrl_if;
  logic [2:0]  addr;
  logic        we;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output addr, we, rd_en, wdata,
    input  rdata
  );

  modport slave (
    input  addr, we, rd_en, wdata,
    output rdata
  );
endinterface

// File: rtl/int_priority_ctrl.sv
// Priority interrupt controller with claim/complete and nesting.
// Source 0 is highest priority; irq feeds one CP0 HWInt bit.
module int_priority_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_irq,
  int_priority_ctrl_if.slave bus,
  output logic             irq
);

  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] enable_q;
  logic [N_SRC-1:0] mode_q;
  logic [N_SRC-1:0] insvc_q;
  logic [N_SRC-1:0] prev_q;

  logic [N_SRC-1:0] pend_eff;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] claim_oh;
  logic [N_SRC-1:0] cmp_oh;
  logic [N_SRC-1:0] mode_n;
  logic [N_SRC-1:0] pend_n;
  logic [N_SRC-1:0] insvc_n;
  logic [4:0]       cur_pri;
  logic [3:0]       claim_id;
  logic             rd_claim;
  logic             wr_pend;
  logic             wr_en;
  logic             wr_mode;
  logic             wr_cmp;

  // Bits above the source count are never decoded.
  logic unused_wdata;
  assign unused_wdata = ^bus.wdata;

  // Level sources read the live line; latched bits only for edge mode.
  assign pend_eff = (pend_q & mode_q) | (src_irq & ~mode_q);
  assign eligible = pend_eff & enable_q & ~insvc_q;
  assign rise     = src_irq & ~prev_q & mode_q;

  always_comb begin
    cur_pri = 5'(N_SRC);
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (insvc_q[i]) cur_pri = 5'(i);
    end
  end

  always_comb begin
    claim_id = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i] && (5'(i) < cur_pri)) claim_id = 4'(i + 1);
    end
  end

  // A write wins over a read if both strobes are seen together.
  assign wr_pend  = bus.we && (bus.addr == 3'd0);
  assign wr_en    = bus.we && (bus.addr == 3'd1);
  assign wr_mode  = bus.we && (bus.addr == 3'd2);
  assign wr_cmp   = bus.we && (bus.addr == 3'd3);
  assign rd_claim = bus.rd_en && !bus.we && (bus.addr == 3'd3);

  assign w1c    = wr_pend ? bus.wdata[N_SRC-1:0] : '0;
  assign mode_n = wr_mode ? bus.wdata[N_SRC-1:0] : mode_q;

  always_comb begin
    claim_oh = '0;
    cmp_oh   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      claim_oh[i] = rd_claim && (claim_id == 4'(i + 1));
      cmp_oh[i]   = wr_cmp && (bus.wdata[3:0] == 4'(i + 1));
    end
  end

  assign pend_n  = ((pend_q & ~w1c & ~(claim_oh & mode_q)) | rise)
                 & mode_n;
  assign insvc_n = (insvc_q | claim_oh) & ~cmp_oh;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= '0;
      enable_q <= '0;
      mode_q   <= '0;
      insvc_q  <= '0;
      prev_q   <= '0;
      irq      <= 1'b0;
    end else begin
      pend_q   <= pend_n;
      enable_q <= wr_en ? bus.wdata[N_SRC-1:0] : enable_q;
      mode_q   <= mode_n;
      insvc_q  <= insvc_n;
      prev_q   <= src_irq;
      irq      <= (claim_id != 4'd0);
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr)
      3'd0: bus.rdata = 32'(pend_eff);
      3'd1: bus.rdata = 32'(enable_q);
      3'd2: bus.rdata = 32'(mode_q);
      3'd3: bus.rdata = 32'(claim_id);
      3'd4: bus.rdata = 32'(insvc_q);
      3'd5: bus.rdata = {24'd0, claim_id, 3'd0, irq};
      default: bus.rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_int_priority_ctrl.sv
// Randomized bench for int_priority_ctrl against a per-source model.
// Directed scenarios first, then random bus traffic and resets.
module tb_int_priority_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] src;
  logic         irq;

  int_priority_ctrl_if bus ();

  int_priority_ctrl #(.N_SRC(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .src_irq (src),
    .bus     (bus),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  bit m_pend [N];
  bit m_en   [N];
  bit m_mode [N];
  bit m_svc  [N];
  bit m_prev [N];
  bit m_irq;

  logic [N-1:0] s_hold;
  logic [31:0]  r;
  logic         q;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_pending(int i);
    return m_mode[i] ? m_pend[i] : src[i];
  endfunction

  function automatic int m_cur();
    for (int i = 0; i < N; i++)
      if (m_svc[i]) return i;
    return N;
  endfunction

  // Highest-priority enabled, not-in-service source above the service level.
  function automatic int m_claim();
    int cur = m_cur();
    for (int i = 0; i < cur; i++)
      if (m_pending(i) && m_en[i] && !m_svc[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(int a);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < N; i++) begin
      case (a)
        0: v[i] = m_pending(i);
        1: v[i] = m_en[i];
        2: v[i] = m_mode[i];
        4: v[i] = m_svc[i];
        default: ;
      endcase
    end
    if (a == 3) v = m_claim();
    if (a == 5) v = (m_claim() << 4) | 32'(m_irq);
    return v;
  endfunction

  task automatic m_update(bit rs, int a, bit w, bit rd, logic [31:0] wd);
    int  id;
    bit  nm;
    if (rs) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_en[i] = 0; m_mode[i] = 0;
        m_svc[i] = 0;  m_prev[i] = 0;
      end
      m_irq = 0;
      return;
    end
    id = m_claim();
    for (int i = 0; i < N; i++) begin
      if (w && a == 0 && wd[i]) m_pend[i] = 0;
      if (!w && rd && a == 3 && id == i + 1) begin
        m_svc[i] = 1;
        if (m_mode[i]) m_pend[i] = 0;
      end
      if (src[i] && !m_prev[i] && m_mode[i]) m_pend[i] = 1;
      nm = (w && a == 2) ? wd[i] : m_mode[i];
      if (!nm) m_pend[i] = 0;
      m_mode[i] = nm;
      if (w && a == 3 && 32'(wd[3:0]) == i + 1) m_svc[i] = 0;
      if (w && a == 1) m_en[i] = wd[i];
      m_prev[i] = src[i];
    end
    m_irq = (id != 0);
  endtask

  task automatic step(input bit rs, input logic [N-1:0] sv, input int a,
                      input bit w, input bit rd, input logic [31:0] wd,
                      output logic [31:0] ro, output logic io);
    @(negedge clk);
    reset     = rs;
    src       = sv;
    bus.addr  = 3'(a);
    bus.we    = w;
    bus.rd_en = rd;
    bus.wdata = wd;
    #1;
    ro = bus.rdata;
    io = irq;
    if (chk_en) begin
      chk("irq", 32'(irq), 32'(m_irq));
      chk($sformatf("rdata@%0d", a), bus.rdata, m_read(a));
    end
    @(posedge clk);
    m_update(rs, a, w, rd, wd);
  endtask

  task automatic wr(int a, logic [31:0] d);
    step(0, s_hold, a, 1, 0, d, r, q);
  endtask

  task automatic rd(int a);
    step(0, s_hold, a, 0, 1, 0, r, q);
  endtask

  task automatic peek(int a);
    step(0, s_hold, a, 0, 0, 0, r, q);
  endtask

  initial begin
    reset = 1; src = '0; s_hold = '0;
    bus.addr = 0; bus.we = 0; bus.rd_en = 0; bus.wdata = 0;
    step(1, '0, 0, 0, 0, 0, r, q);
    chk_en = 1;
    step(1, '0, 0, 0, 0, 0, r, q);
    peek(5);  chk("rst_status", r, 0);
    chk("rst_irq", 32'(q), 0);

    // Single edge source, claim and complete
    wr(2, 32'hFF); wr(1, 32'h01);
    s_hold = 8'h01; peek(0);
    s_hold = 8'h00; peek(0); chk("t1_pend", r, 32'h01);
    peek(0); chk("t1_irq", 32'(q), 1);
    rd(3);   chk("t1_claim", r, 1);
    peek(4); chk("t1_insvc", r, 32'h01);
    peek(0); chk("t1_pend0", r, 0);
    wr(3, 1);
    peek(4); chk("t1_done", r, 0);

    // Level sources, lower priority blocked while in service
    wr(1, 32'hFF); wr(2, 32'h00);
    s_hold = 8'h24;
    rd(3); chk("t2_claim3", r, 3);
    rd(3); chk("t2_block", r, 0);
    wr(3, 3);
    rd(3); chk("t2_reclaim", r, 3);
    wr(3, 3); s_hold = 8'h00; peek(0); peek(0);

    // Nesting: edge source 1 preempts in-service level source 4
    s_hold = 8'h10;
    rd(3); chk("t3_claim5", r, 5);
    wr(2, 32'h02);
    s_hold = 8'h12; peek(0); peek(0);
    peek(0); chk("t3_irq", 32'(q), 1);
    rd(3); chk("t3_claim2", r, 2);
    peek(4); chk("t3_insvc", r, 32'h12);
    wr(3, 2); peek(0); peek(0);
    peek(0); chk("t3_irq0", 32'(q), 0);
    wr(3, 5); s_hold = 8'h00; peek(0);

    // Set wins over same-cycle W1C
    wr(2, 32'hFF); peek(0);
    s_hold = 8'h08; wr(0, 32'h08);
    peek(0); chk("t4_setwins", r, 32'h08);
    wr(0, 32'h08);
    peek(0); chk("t4_w1c", r, 0);

    // Bad completes leave INSVC alone
    s_hold = 8'h01; peek(0); s_hold = 8'h00; peek(0);
    rd(3); chk("t5_claim", r, 1);
    wr(3, 0); wr(3, 9); wr(3, 7);
    peek(4); chk("t5_insvc", r, 32'h01);
    wr(3, 1); peek(0); peek(0);
    peek(5); chk("t5_status", r, 0);

    // Reset mid-service
    wr(2, 32'h00);
    s_hold = 8'h04; rd(3); chk("t6_c3", r, 3);
    s_hold = 8'h05; rd(3); chk("t6_c1", r, 1);
    peek(4); chk("t6_insvc", r, 32'h05);
    step(1, s_hold, 4, 0, 0, 0, r, q);
    peek(4); chk("t6_rst_insvc", r, 0);
    chk("t6_rst_irq", 32'(q), 0);
    peek(0); peek(0); chk("t6_noen", 32'(q), 0);
    wr(1, 32'hFF); peek(0);
    peek(0); chk("t6_reraise", 32'(q), 1);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      int          a;
      bit          w, rv, rs;
      logic [31:0] d;
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) s_hold[i] = ~s_hold[i];
      a  = $urandom_range(7);
      w  = ($urandom_range(3) == 0);
      rv = ($urandom_range(2) == 0);
      rs = ($urandom_range(299) == 0);
      d  = (a == 3) ? 32'($urandom_range(15)) : $urandom;
      step(rs, s_hold, a, w, rv, d, r, q);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
